// File: rtl/project_1.sv
// Single-cycle RV32I-subset core with internal instruction ROM and data RAM.
// Define PROJECT_1_TRACE_EN to print register writebacks and stores.
module project_1 #(
    parameter int    IMEM_DEPTH = 256,
    parameter int    DMEM_DEPTH = 256,
    parameter string IMEM_FILE  = "imem.hex"
) (
    input logic clk,
    input logic reset
);

    localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    logic [31:0] pc;
    logic [31:0] rf   [0:31];
    logic [31:0] imem [0:IMEM_DEPTH-1];
    logic [31:0] dmem [0:DMEM_DEPTH-1];

    logic [IAW-1:0] iidx;
    logic [31:0]    instr;
    logic [6:0]     opcode;
    logic [4:0]     rd, rs1, rs2;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic [31:0]    imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0]    rs1_val, rs2_val;
    logic [31:0]    pc_plus4;

    assign iidx   = IAW'({2'b00, pc[31:2]} % IMEM_DEPTH);
    assign instr  = imem[iidx];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    // x0 storage is never written, but muxing keeps reads defined before the first reset
    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
    assign pc_plus4 = pc + 32'd4;

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction

    alu_op_t base_op, r_op, i_op, alu_sel;
    logic    f7_zero, f7_alt, r_legal, i_legal;
    logic [31:0] alu_b, alu_y;

    always_comb begin
        case (funct3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    end

    // funct7 = 0x20 only selects sub/sra; any other nonzero funct7 (e.g. M-extension) is a NOP
    assign f7_zero = (funct7 == 7'h00);
    assign f7_alt  = (funct7 == 7'h20);
    assign r_legal = f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));
    assign r_op    = f7_alt ? ((funct3 == 3'b000) ? ALU_SUB : ALU_SRA) : base_op;
    assign i_legal = (funct3 == 3'b001) ? f7_zero :
                     (funct3 == 3'b101) ? (f7_zero || f7_alt) : 1'b1;
    assign i_op    = (funct3 == 3'b101 && f7_alt) ? ALU_SRA : base_op;

    assign alu_sel = (opcode == OPC_OP) ? r_op : i_op;
    assign alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign alu_y   = alu(alu_sel, rs1_val, alu_b);

    logic br_take;
    always_comb begin
        case (funct3)
            3'b000:  br_take = (rs1_val == rs2_val);
            3'b001:  br_take = (rs1_val != rs2_val);
            3'b100:  br_take = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_take = ($signed(rs1_val) >= $signed(rs2_val));
            default: br_take = 1'b0;
        endcase
    end

    logic [31:0]    d_addr;
    logic [DAW-1:0] didx;
    logic           unused_addr_lsbs;

    assign d_addr           = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign didx             = DAW'({2'b00, d_addr[31:2]} % DMEM_DEPTH);
    assign unused_addr_lsbs = ^d_addr[1:0];

    logic        rf_we, mem_we;
    logic [31:0] wdata, pc_next;

    always_comb begin
        rf_we   = 1'b0;
        mem_we  = 1'b0;
        wdata   = alu_y;
        pc_next = pc_plus4;
        case (opcode)
            OPC_OP:     rf_we = r_legal;
            OPC_OPIMM:  rf_we = i_legal;
            OPC_LOAD: begin
                rf_we = (funct3 == 3'b010);
                wdata = dmem[didx];
            end
            OPC_STORE:  mem_we = (funct3 == 3'b010);
            OPC_BRANCH: if (br_take) pc_next = pc + imm_b;
            OPC_JAL: begin
                rf_we   = 1'b1;
                wdata   = pc_plus4;
                pc_next = pc + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    rf_we   = 1'b1;
                    wdata   = pc_plus4;
                    pc_next = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OPC_LUI: begin
                rf_we = 1'b1;
                wdata = imm_u;
            end
            OPC_AUIPC: begin
                rf_we = 1'b1;
                wdata = pc + imm_u;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            pc <= pc_next;
            if (rf_we && rd != 5'd0) rf[rd] <= wdata;
`ifdef PROJECT_1_TRACE_EN
            if (rf_we && rd != 5'd0) $display("%0t pc=%h x%0d=%h", $time, pc, rd, wdata);
            if (mem_we) $display("%0t pc=%h sw addr=%h data=%h", $time, pc, d_addr, rs2_val);
`endif
        end
    end

    // Data memory keeps its contents across reset
    always_ff @(posedge clk) begin
        if (!reset && mem_we) dmem[didx] <= rs2_val;
    end

endmodule

// File: tb/tb_project_1.sv
// Directed bench for project_1: programs are poked into imem, expectations queued
// as each program is set up and popped against pc/rf/dmem after it runs.
module tb_project_1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    project_1 #(.IMEM_FILE("")) dut (
        .clk   (clk),
        .reset (reset)
    );

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] r_op(logic [31:0] f7, f3, rd, rs1, rs2);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] i_op(logic [31:0] f3, rd, rs1, imm, op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] s_op(logic [31:0] rs2, rs1, imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_op(logic [31:0] f3, rs1, rs2, imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] j_op(logic [31:0] rd, imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] u_op(logic [31:0] rd, imm, op);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] addi(logic [31:0] rd, rs1, imm);
        return i_op(0, rd, rs1, imm, 'h13);
    endfunction
    function automatic logic [31:0] lw(logic [31:0] rd, rs1, imm);
        return i_op(2, rd, rs1, imm, 'h03);
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 256; i++) begin
            dut.imem[i[7:0]] = (i < prog.size()) ? prog[i] : 32'h0;
        end
    endtask

    task automatic push(string tag, int kind, int idx, logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sb.push_back(e);
    endtask
    task automatic exp_pc(logic [31:0] v);
        push("pc", 0, 0, v);
    endtask
    task automatic exp_rf(int r, logic [31:0] v);
        push($sformatf("x%0d", r), 1, r, v);
    endtask
    task automatic exp_dm(int i, logic [31:0] v);
        push($sformatf("dmem[%0d]", i), 2, i, v);
    endtask

    task automatic check_all(string phase);
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] obs;
            e = sb.pop_front();
            case (e.kind)
                0:       obs = dut.pc;
                1:       obs = dut.rf[e.idx[4:0]];
                default: obs = dut.dmem[e.idx[7:0]];
            endcase
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s/%s: observed %h expected %h", phase, e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    // Call at a negedge: holds reset across one rising edge with the new program loaded
    task automatic restart();
        reset = 1'b1;
        load_prog();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // ALU
        prog = '{};
        prog.push_back(addi(1, 0, 5));
        prog.push_back(addi(2, 0, -3));
        prog.push_back(r_op(0, 0, 3, 1, 2));
        prog.push_back(r_op(32, 0, 4, 1, 2));
        prog.push_back(r_op(0, 2, 5, 2, 1));
        prog.push_back(r_op(0, 3, 6, 2, 1));
        prog.push_back(addi(7, 0, -16));
        prog.push_back(i_op(5, 8, 7, 'h402, 'h13));
        prog.push_back(i_op(5, 9, 7, 28, 'h13));
        prog.push_back(addi(11, 0, 33));
        prog.push_back(r_op(0, 1, 10, 1, 11));
        prog.push_back(i_op(4, 12, 1, -1, 'h13));
        prog.push_back(i_op(3, 13, 1, -1, 'h13));
        prog.push_back(r_op(32, 5, 14, 2, 1));
        restart();
        exp_pc(0);
        check_all("reset0");
        step(6);
        exp_rf(3, 32'd2);
        exp_rf(4, 32'd8);
        exp_rf(5, 32'd1);
        exp_rf(6, 32'd0);
        exp_pc(32'd24);
        check_all("alu6");
        step(8);
        exp_rf(8, 32'hffff_fffc);
        exp_rf(9, 32'h0000_000f);
        exp_rf(10, 32'd10);
        exp_rf(12, 32'hffff_fffa);
        exp_rf(13, 32'd1);
        exp_rf(14, 32'hffff_ffff);
        exp_pc(32'd56);
        check_all("alu14");

        // Reset with pc nonzero
        reset = 1'b1;
        @(negedge clk);
        exp_pc(0);
        for (int r = 1; r < 32; r++) exp_rf(r, 32'd0);
        check_all("reset");

        // Memory, including index wrap and ignored low address bits
        prog = '{};
        prog.push_back(addi(1, 0, 'h40));
        prog.push_back(addi(2, 0, 'h7b));
        prog.push_back(s_op(2, 1, 0));
        prog.push_back(lw(3, 1, 0));
        prog.push_back(s_op(1, 0, 'h407));
        prog.push_back(lw(5, 1, 3));
        prog.push_back(lw(6, 0, 4));
        prog.push_back(s_op(1, 0, 8));
        restart();
        step(4);
        exp_dm(16, 32'h7b);
        exp_rf(3, 32'h7b);
        check_all("mem4");
        step(4);
        exp_dm(1, 32'h40);
        exp_rf(5, 32'h7b);
        exp_rf(6, 32'h40);
        exp_dm(2, 32'h40);
        exp_pc(32'd32);
        check_all("mem8");

        // Branches and jumps
        prog = '{};
        prog.push_back(b_op(0, 0, 0, 8));
        prog.push_back(addi(9, 0, 1));
        prog.push_back(j_op(1, 12));
        prog.push_back(addi(9, 0, 2));
        prog.push_back(addi(9, 0, 3));
        prog.push_back(b_op(1, 0, 0, 8));
        prog.push_back(addi(10, 0, 7));
        prog.push_back(addi(12, 0, 45));
        prog.push_back(i_op(0, 11, 12, 0, 'h67));
        prog.push_back(addi(9, 0, 4));
        prog.push_back(addi(9, 0, 5));
        prog.push_back(addi(13, 0, -1));
        prog.push_back(b_op(4, 13, 0, 8));
        prog.push_back(addi(9, 0, 6));
        prog.push_back(b_op(5, 13, 0, 8));
        prog.push_back(addi(14, 0, 1));
        restart();
        step(1);
        exp_pc(32'd8);
        check_all("beq");
        step(1);
        exp_pc(32'd20);
        exp_rf(1, 32'd12);
        check_all("jal");
        step(1);
        exp_pc(32'd24);
        check_all("bne");
        step(7);
        exp_rf(9, 32'd0);
        exp_rf(10, 32'd7);
        exp_rf(11, 32'd36);
        exp_rf(13, 32'hffff_ffff);
        exp_rf(14, 32'd1);
        exp_pc(32'd64);
        check_all("ctrl");

        // x0, upper immediates, unsupported encodings as NOP
        prog = '{};
        prog.push_back(addi(0, 0, 9));
        prog.push_back(u_op(7, 'h12345, 'h37));
        prog.push_back(32'h0);
        prog.push_back(r_op(1, 0, 15, 1, 1));
        prog.push_back(u_op(8, 1, 'h17));
        prog.push_back(b_op(7, 0, 0, 8));
        restart();
        step(6);
        exp_rf(0, 32'd0);
        exp_rf(7, 32'h1234_5000);
        exp_rf(8, 32'h0000_1010);
        exp_rf(15, 32'd0);
        exp_pc(32'd24);
        check_all("upper");

        // Mid-run reset aborts the in-flight sw, then the program reruns cleanly
        prog = '{};
        prog.push_back(addi(1, 0, 10));
        prog.push_back(addi(2, 0, 3));
        prog.push_back(r_op(0, 0, 3, 1, 2));
        prog.push_back(r_op(32, 0, 4, 1, 2));
        prog.push_back(s_op(3, 0, 8));
        prog.push_back(lw(5, 0, 8));
        prog.push_back(addi(5, 5, 1));
        prog.push_back(r_op(0, 4, 6, 1, 2));
        prog.push_back(i_op(1, 7, 2, 4, 'h13));
        prog.push_back(r_op(0, 6, 8, 4, 7));
        prog.push_back(addi(9, 0, -1));
        restart();
        step(4);
        exp_rf(4, 32'd7);
        check_all("pre");
        reset = 1'b1;
        @(negedge clk);
        exp_pc(0);
        exp_rf(3, 32'd0);
        exp_dm(2, 32'h40);
        check_all("midreset");
        reset = 1'b0;
        step(11);
        exp_rf(1, 32'd10);
        exp_rf(2, 32'd3);
        exp_rf(3, 32'd13);
        exp_rf(4, 32'd7);
        exp_rf(5, 32'd14);
        exp_rf(6, 32'd9);
        exp_rf(7, 32'd48);
        exp_rf(8, 32'h37);
        exp_rf(9, 32'hffff_ffff);
        exp_dm(2, 32'd13);
        exp_pc(32'd44);
        check_all("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
